demux2out16b_queue: RTL and testbench

Registered 1-to-2 demultiplexer for 16-bit words: the steering counterpart of the datapath's 2-input 16-bit selector. One producer presents words with a valid/ready handshake; each word goes to one of two consumers according to `in_control`. Each output has its own small FIFO, so a stalled consumer never corrupts or reorders the other path. It sits between a single datapath result source and two independent sinks, for example a register-write port and a memory-write staging path.

---
 rtl/demux2out16b_queue.sv | 86 ++++++++
 tb/tb_demux2out16b_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/demux2out16b_queue.sv
// rtl/demux2out16b_queue.sv - registered 1-to-2 word demultiplexer with a small FIFO per output
module demux2out16b_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_control,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [WIDTH-1:0]         out2_data,
  output logic                     out2_valid,
  input  logic                     out2_ready,
  output logic [$clog2(DEPTH):0]   out1_level,
  output logic [$clog2(DEPTH):0]   out2_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    wr_ptr_d [2];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [PW-1:0]    rd_ptr_d [2];
  logic [LW-1:0]    level_q  [2];
  logic [LW-1:0]    level_d  [2];
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       pop_ready;

  assign pop_ready = {out2_ready, out1_ready};
  assign full[0]   = (level_q[0] == FULL_LEVEL);
  assign full[1]   = (level_q[1] == FULL_LEVEL);

  // Readiness comes only from registered level, so a full queue refuses even while popping.
  assign in_ready = !full[in_control];

  always_comb begin
    push = 2'b00;
    pop  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      level_d[i]  = level_q[i];
      push[i] = in_valid && in_ready && (in_control == i[0]);
      pop[i]  = (level_q[i] != '0) && pop_ready[i];
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      if (push[i] && !pop[i])      level_d[i] = level_q[i] + 1'b1;
      else if (!push[i] && pop[i]) level_d[i] = level_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        level_q[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        level_q[i]  <= level_d[i];
        if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data;
      end
    end
  end

  assign out1_valid = (level_q[0] != '0);
  assign out2_valid = (level_q[1] != '0);
  assign out1_data  = mem_q[0][rd_ptr_q[0]];
  assign out2_data  = mem_q[1][rd_ptr_q[1]];
  assign out1_level = level_q[0];
  assign out2_level = level_q[1];

endmodule

// File: tb/tb_demux2out16b_queue.sv
// tb/tb_demux2out16b_queue.sv - randomized and directed bench against a queue-based reference model
module tb_demux2out16b_queue;

  localparam int W = 16;
  localparam int D = 2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_control = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out1_data, out2_data;
  logic         out1_valid, out2_valid;
  logic         out1_ready = 1'b0;
  logic         out2_ready = 1'b0;
  logic [1:0]   out1_level, out2_level;

  always #5 clock = ~clock;

  demux2out16b_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_data(in_data), .in_control(in_control), .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .out1_level(out1_level), .out2_level(out2_level)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic [W-1:0] d,
                       input logic r1, input logic r2);
    in_valid = v; in_control = c; in_data = d; out1_ready = r1; out2_ready = r2;
  endtask

  task automatic check_outputs();
    chk("out1_valid", out1_valid, q1.size() != 0);
    chk("out2_valid", out2_valid, q2.size() != 0);
    chk("out1_level", out1_level, q1.size());
    chk("out2_level", out2_level, q2.size());
    if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
    if (q2.size() != 0) chk("out2_data", out2_data, q2[0]);
  endtask

  // One clock: check in_ready against the model, let the edge happen, advance the model.
  task automatic cycle();
    bit rdy_m, push, p1, p2;
    #1;
    rdy_m = ((in_control ? q2.size() : q1.size()) != D);
    chk("in_ready", in_ready, rdy_m);
    push = in_valid && rdy_m;
    p1 = (q1.size() != 0) && out1_ready;
    p2 = (q2.size() != 0) && out2_ready;
    @(posedge clock); #1;
    if (p1) void'(q1.pop_front());
    if (p2) void'(q2.pop_front());
    if (push) begin
      if (in_control) q2.push_back(in_data);
      else            q1.push_back(in_data);
    end
    check_outputs();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_v1"}, out1_valid, 0);
    chk({tag, "_v2"}, out2_valid, 0);
    chk({tag, "_d1"}, out1_data, 0);
    chk({tag, "_d2"}, out2_data, 0);
    chk({tag, "_l1"}, out1_level, 0);
    chk({tag, "_l2"}, out2_level, 0);
    in_control = 1'b0; #1;
    chk({tag, "_rdy_c0"}, in_ready, 1);
    in_control = 1'b1; #1;
    chk({tag, "_rdy_c1"}, in_ready, 1);
  endtask

  // Asserts reset mid-cycle, holds it across one edge, releases before the next edge.
  task automatic mid_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    q1.delete(); q2.delete();
    check_reset_state(tag);
    @(posedge clock); #1;
    check_outputs();
    reset_n = 1'b1;
    drive(0, 0, '0, 0, 0);
  endtask

  logic [W-1:0] rx[$];
  int k;

  initial begin
    #3;
    check_reset_state("por");
    @(posedge clock); #1;
    reset_n = 1'b1;

    mid_reset("rst1");
    drive(1, 0, 16'h1234, 0, 0); cycle();
    chk("t1_data", out1_data, 16'h1234);
    chk("t1_level", out1_level, 1);
    chk("t1_v2", out2_valid, 0);
    drive(0, 0, '0, 1, 1); cycle();

    drive(1, 0, 16'hA001, 0, 0); cycle();
    drive(1, 0, 16'hA002, 0, 0); cycle();
    chk("t2_level_full", out1_level, 2);
    drive(1, 0, 16'hA003, 0, 0); #1;
    chk("t2_rdy_full", in_ready, 0);
    cycle();
    chk("t2_held_level", out1_level, 2);
    in_control = 1'b1; #1;
    chk("t2_rdy_other", in_ready, 1);
    in_control = 1'b0;

    drive(1, 0, 16'hA003, 1, 0); cycle();
    chk("t3_refused_level", out1_level, 1);
    chk("t3_head", out1_data, 16'hA002);
    cycle();
    chk("t3_level_same", out1_level, 1);
    chk("t3_head2", out1_data, 16'hA003);
    drive(0, 0, '0, 1, 1); cycle();
    chk("t3_drained", out1_valid, 0);

    drive(1, 0, 16'h0001, 1, 1); cycle();
    chk("t4_o1a", out1_data, 16'h0001);
    drive(1, 1, 16'h0002, 1, 1); cycle();
    chk("t4_o2a", out2_data, 16'h0002);
    drive(1, 0, 16'h0003, 1, 1); cycle();
    chk("t4_o1b", out1_data, 16'h0003);
    drive(1, 1, 16'h0004, 1, 1); cycle();
    chk("t4_o2b", out2_data, 16'h0004);
    drive(0, 0, '0, 1, 1); cycle();

    k = 0;
    rx.delete();
    for (int cyc = 0; cyc < 80 && rx.size() < 10; cyc++) begin
      drive(k < 10, 1, 16'h0100 + W'(k), 0, cyc[0]);
      #1;
      if (out2_valid && out2_ready) rx.push_back(out2_data);
      if (in_valid && q2.size() != D) k++;
      cycle();
      chk("t5_level_max", out2_level <= 2, 1);
    end
    chk("t5_count", rx.size(), 10);
    for (int i = 0; i < 10 && i < rx.size(); i++) chk("t5_order", rx[i], 16'h0100 + i);

    drive(1, 1, 16'hBEE1, 0, 0); cycle();
    drive(1, 1, 16'hBEE2, 0, 0); cycle();
    chk("t6_pre_level", out2_level, 2);
    drive(0, 0, '0, 0, 1);
    mid_reset("rst2");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, 1, 1); cycle();
      chk("t6_gone", out2_valid, 0);
    end

    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), W'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 1));
      cycle();
    end
    drive(0, 0, '0, 1, 1);
    cycle(); cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
